// File: rtl/tlp_pkg.sv
// Shared definitions for the memory-write TLP generator: state encoding,
// header field positions and the 4DW MWr64 header builder.
package tlp_pkg;

   localparam logic [2:0] FMT_MWR64 = 3'b011;
   localparam logic [4:0] TYPE_MEM  = 5'b00000;

   localparam int HDR_W    = 128;
   localparam int FMT_LSB  = 125;
   localparam int TYPE_LSB = 120;
   localparam int LEN_LSB  = 96;
   localparam int TAG_LSB  = 72;
   localparam int LBE_LSB  = 68;
   localparam int FBE_LSB  = 64;
   localparam int ADDR_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP,
      ST_DONE
   } tlp_state_e;

   function automatic logic [HDR_W-1:0] build_hdr(input logic [9:0]  len,
                                                  input logic [7:0]  tag,
                                                  input logic [63:0] addr);
      logic [HDR_W-1:0] h;
      h = '0;
      h[FMT_LSB  +: 3]  = FMT_MWR64;
      h[TYPE_LSB +: 5]  = TYPE_MEM;
      h[LEN_LSB  +: 10] = len;
      h[TAG_LSB  +: 8]  = tag;
      h[FBE_LSB  +: 4]  = 4'hF;
      // single-DW writes must carry a zero last-BE
      h[LBE_LSB  +: 4]  = (len > 10'd1) ? 4'hF : 4'h0;
      h[ADDR_LSB +: 64] = addr;
      return h;
   endfunction

endpackage

// File: rtl/tlp_beat_fmt.sv
// Combinational payload generator: fills one data beat with the
// {packet, DW index} pattern, zeroes unused DWs and reports EOP/empty.
module tlp_beat_fmt
   import tlp_pkg::*;
#(
   parameter int DW             = 32,
   parameter int TLP_DATA_WIDTH = 8*DW,
   parameter int LEN_W          = 7,
   parameter int BEAT_DW        = TLP_DATA_WIDTH/DW,
   parameter int EMPTY_W        = $clog2(BEAT_DW)
) (
   input  logic [15:0]               pkt_idx,
   input  logic [15:0]               beat_idx,
   input  logic [LEN_W-1:0]          len,
   output logic [TLP_DATA_WIDTH-1:0] data,
   output logic [EMPTY_W-1:0]        empty,
   output logic                      last
);

   always_comb begin
      logic [31:0] base;
      logic [31:0] g;
      logic [31:0] len32;
      logic [31:0] rem;
      len32 = 32'(len);
      base  = 32'(beat_idx) * 32'(BEAT_DW);
      g     = '0;
      data  = '0;
      for (int unsigned k = 0; k < BEAT_DW; k++) begin
         g = base + k;
         if (g < len32)
            data[DW*k +: DW] = DW'({pkt_idx, g[15:0]});
      end
      last  = (base + 32'(BEAT_DW)) >= len32;
      rem   = len32 % 32'(BEAT_DW);
      empty = (rem == 32'd0) ? '0 : EMPTY_W'(32'(BEAT_DW) - rem);
   end

endmodule

// File: rtl/tlp_gen.sv
// Burst source of 4DW memory-write TLPs on a valid/ready stream with
// programmable length, inter-packet gap and incrementing address.
module tlp_gen
   import tlp_pkg::*;
#(
   parameter int DW             = 32,
   parameter int HEADER_SIZE    = 4*DW,
   parameter int TLP_DATA_WIDTH = 8*DW,
   parameter int MAX_LEN_DW     = 64,
   parameter int LEN_W          = $clog2(MAX_LEN_DW+1),
   parameter int BEAT_DW        = TLP_DATA_WIDTH/DW
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic [15:0]                 cfg_num_pkts,
   input  logic [LEN_W-1:0]            cfg_len_dw,
   input  logic [63:0]                 cfg_addr,
   input  logic [7:0]                  cfg_gap,
   output logic                        busy,
   output logic                        done,
   output logic [15:0]                 pkt_cnt,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic                        out_sop,
   output logic                        out_eop,
   output logic [HEADER_SIZE-1:0]      out_hdr,
   output logic [TLP_DATA_WIDTH-1:0]   out_data,
   output logic [$clog2(BEAT_DW)-1:0]  out_empty
);

   localparam int EMPTY_W = $clog2(BEAT_DW);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN_DW);

   tlp_state_e        state_q;
   logic [15:0]       num_q;
   logic [LEN_W-1:0]  len_q;
   logic [7:0]        gap_q;
   logic [7:0]        gap_cnt;
   logic [63:0]       addr_q;
   logic [15:0]       p_q;
   logic [15:0]       b_q;
   logic              abort_q;

   logic [LEN_W-1:0]  len_eff;
   logic              hs;
   logic              last_pkt;
   logic              abort_eff;
   logic [63:0]       stride;
   logic              ld;
   logic              adv;
   logic [15:0]       sel_p;
   logic [15:0]       sel_b;
   logic [63:0]       sel_addr;
   logic              sel_sop;

   logic [TLP_DATA_WIDTH-1:0] fmt_data;
   logic [EMPTY_W-1:0]        fmt_empty;
   logic                      fmt_last;

   always_comb begin
      len_eff = cfg_len_dw;
      if (cfg_len_dw == '0)
         len_eff = LEN_W'(1);
      else if (cfg_len_dw > MAX_LEN_L)
         len_eff = MAX_LEN_L;
   end

   assign hs        = out_valid & out_ready;
   assign last_pkt  = (p_q == num_q - 16'd1);
   assign abort_eff = abort_q | abort;
   assign stride    = 64'(len_q) << 2;

   // Pick the beat to load into the output stage this cycle; p_q/addr_q
   // always describe the packet whose beats are (or are next) presented.
   always_comb begin
      ld    = 1'b0;
      adv   = 1'b0;
      sel_b = b_q;
      case (state_q)
         ST_SEND: begin
            if (!out_valid) begin
               ld = 1'b1;
            end else if (hs) begin
               if (!out_eop) begin
                  ld    = 1'b1;
                  sel_b = b_q + 16'd1;
               end else if (!last_pkt && !abort_eff && gap_q == 8'd0) begin
                  ld    = 1'b1;
                  adv   = 1'b1;
                  sel_b = '0;
               end
            end
         end
         ST_GAP: begin
            if (!abort_eff && gap_cnt == 8'd1)
               ld = 1'b1;
         end
         default: ;
      endcase
      sel_p    = adv ? p_q + 16'd1 : p_q;
      sel_addr = adv ? addr_q + stride : addr_q;
      sel_sop  = (sel_b == 16'd0);
   end

   tlp_beat_fmt #(
      .DW             (DW),
      .TLP_DATA_WIDTH (TLP_DATA_WIDTH),
      .LEN_W          (LEN_W),
      .BEAT_DW        (BEAT_DW),
      .EMPTY_W        (EMPTY_W)
   ) u_fmt (
      .pkt_idx  (sel_p),
      .beat_idx (sel_b),
      .len      (len_q),
      .data     (fmt_data),
      .empty    (fmt_empty),
      .last     (fmt_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         num_q     <= '0;
         len_q     <= '0;
         gap_q     <= '0;
         gap_cnt   <= '0;
         addr_q    <= '0;
         p_q       <= '0;
         b_q       <= '0;
         abort_q   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pkt_cnt   <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_hdr   <= '0;
         out_data  <= '0;
         out_empty <= '0;
      end else begin
         done <= 1'b0;
         if (busy && abort)
            abort_q <= 1'b1;

         if (ld) begin
            out_valid <= 1'b1;
            out_sop   <= sel_sop;
            out_eop   <= fmt_last;
            out_hdr   <= sel_sop ? HEADER_SIZE'(build_hdr(10'(len_q), sel_p[7:0], sel_addr)) : '0;
            out_data  <= fmt_data;
            out_empty <= fmt_last ? fmt_empty : '0;
            b_q       <= sel_b;
            if (adv) begin
               p_q    <= p_q + 16'd1;
               addr_q <= addr_q + stride;
            end
         end else if (hs) begin
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_hdr   <= '0;
            out_data  <= '0;
            out_empty <= '0;
         end

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  pkt_cnt <= '0;
                  num_q   <= cfg_num_pkts;
                  len_q   <= len_eff;
                  gap_q   <= cfg_gap;
                  addr_q  <= {cfg_addr[63:2], 2'b00};
                  p_q     <= '0;
                  b_q     <= '0;
                  abort_q <= 1'b0;
                  if (cfg_num_pkts != 16'd0) begin
                     state_q <= ST_SEND;
                     busy    <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (hs && out_eop) begin
                  pkt_cnt <= pkt_cnt + 16'd1;
                  if (last_pkt || abort_eff) begin
                     state_q <= ST_DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else if (gap_q != 8'd0) begin
                     state_q <= ST_GAP;
                     gap_cnt <= gap_q;
                     p_q     <= p_q + 16'd1;
                     b_q     <= '0;
                     addr_q  <= addr_q + stride;
                  end
               end
            end
            ST_GAP: begin
               if (abort_eff) begin
                  state_q <= ST_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else if (gap_cnt == 8'd1) begin
                  state_q <= ST_SEND;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               abort_q <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tlp_gen.sv
// Directed bench for tlp_gen: bursts, gaps, stalls, abort, clamping,
// address wrap and mid-packet reset, checked against hand-derived values.
module tb_tlp_gen;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [15:0]  cfg_num_pkts = '0;
   logic [6:0]   cfg_len_dw = '0;
   logic [63:0]  cfg_addr = '0;
   logic [7:0]   cfg_gap = '0;
   logic         busy;
   logic         done;
   logic [15:0]  pkt_cnt;
   logic         out_ready = 1'b1;
   logic         out_valid;
   logic         out_sop;
   logic         out_eop;
   logic [127:0] out_hdr;
   logic [255:0] out_data;
   logic [2:0]   out_empty;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   typedef struct {
      logic         sop;
      logic         eop;
      logic [2:0]   empty;
      logic [127:0] hdr;
      logic [255:0] data;
      int           cyc;
   } beat_t;

   beat_t beats[$];
   beat_t ref_beats[$];
   int    done_cycs[$];
   logic  stall_q = 1'b0;
   logic [388:0] snap = '0;

   tlp_gen #(
      .DW         (32),
      .MAX_LEN_DW (64)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .cfg_num_pkts (cfg_num_pkts),
      .cfg_len_dw   (cfg_len_dw),
      .cfg_addr     (cfg_addr),
      .cfg_gap      (cfg_gap),
      .busy         (busy),
      .done         (done),
      .pkt_cnt      (pkt_cnt),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .out_sop      (out_sop),
      .out_eop      (out_eop),
      .out_hdr      (out_hdr),
      .out_data     (out_data),
      .out_empty    (out_empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [399:0] got, input logic [399:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [388:0] out_vec();
      return {out_sop, out_eop, out_empty, out_hdr, out_data};
   endfunction

   function automatic logic [388:0] beat_vec(input beat_t b);
      return {b.sop, b.eop, b.empty, b.hdr, b.data};
   endfunction

   function automatic beat_t get_beat(input int i);
      beat_t b;
      b = '{sop: 1'b0, eop: 1'b0, empty: 3'd0, hdr: '0, data: '0, cyc: -1};
      if (i >= 0 && i < beats.size())
         b = beats[i];
      return b;
   endfunction

   // Monitor: records accepted beats and done pulses, checks stall stability.
   always @(negedge clk) begin
      if (rst_n && stall_q)
         check("stall_stable", {out_valid, out_vec()}, {1'b1, snap});
      stall_q <= rst_n && out_valid && !out_ready;
      snap    <= out_vec();
      if (rst_n && out_valid && out_ready)
         beats.push_back('{sop: out_sop, eop: out_eop, empty: out_empty,
                           hdr: out_hdr, data: out_data, cyc: cyc});
      if (done)
         done_cycs.push_back(cyc);
   end

   task automatic run_burst(input string name, input int num, input int len,
                            input logic [63:0] addr, input int gap, input bit rnd,
                            input int abort_at, output int t_start);
      bit fin;
      bit ab_done;
      bit pulse;
      fin = 0;
      ab_done = 0;
      beats.delete();
      done_cycs.delete();
      @(posedge clk); #1;
      cfg_num_pkts = 16'(num);
      cfg_len_dw   = 7'(len);
      cfg_addr     = addr;
      cfg_gap      = 8'(gap);
      start        = 1'b1;
      t_start      = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3000 && !fin; i++) begin
         @(negedge clk); #1;
         if (done) begin
            fin = 1;
         end else begin
            pulse = (abort_at >= 0) && (beats.size() == abort_at) && !ab_done;
            @(posedge clk); #1;
            abort = pulse;
            if (pulse) ab_done = 1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
         end
      end
      abort = 1'b0;
      out_ready = 1'b1;
      if (!fin)
         check({name, "_timeout"}, 0, 1);
      repeat (3) @(negedge clk);
      #1;
      check({name, "_done_pulses"}, done_cycs.size(), 1);
      check({name, "_busy_idle"}, busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      bit fin;
      beat_t b;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outs", {out_valid, out_sop, out_eop, busy, done, pkt_cnt, out_hdr, out_data, out_empty}, '0);
      #1 rst_n = 1'b1;

      // single 1-beat packet
      run_burst("t1", 1, 8, 64'h1000, 0, 0, -1, t0);
      b = get_beat(0);
      check("t1_nbeats", beats.size(), 1);
      check("t1_sop_eop_empty", {b.sop, b.eop, b.empty}, {1'b1, 1'b1, 3'd0});
      check("t1_hdr", b.hdr, 128'h60000008_000000FF_00000000_00001000);
      check("t1_dw3", b.data[127:96], 32'h0000_0003);
      check("t1_data", b.data, 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
      check("t1_latency", b.cyc - t0, 2);
      check("t1_done_time", done_cycs.size() > 0 ? done_cycs[0] - b.cyc : -1, 1);
      check("t1_pkt_cnt", pkt_cnt, 1);

      // three 3-beat packets with a 2-cycle gap
      run_burst("t2", 3, 20, 64'h1000, 2, 0, -1, t0);
      check("t2_nbeats", beats.size(), 9);
      check("t2_hdr0", get_beat(0).hdr, 128'h60000014_000000FF_00000000_00001000);
      check("t2_hdr1", get_beat(3).hdr, 128'h60000014_000001FF_00000000_00001050);
      check("t2_hdr2", get_beat(6).hdr, 128'h60000014_000002FF_00000000_000010A0);
      check("t2_mid_hdr_zero", get_beat(1).hdr, '0);
      check("t2_sop_flags", {get_beat(0).sop, get_beat(1).sop, get_beat(2).sop, get_beat(3).sop}, 4'b1001);
      check("t2_eop_flags", {get_beat(0).eop, get_beat(1).eop, get_beat(2).eop, get_beat(5).eop}, 4'b0011);
      check("t2_eop_empty", get_beat(2).empty, 3'd4);
      check("t2_mid_empty", get_beat(1).empty, 3'd0);
      check("t2_b0_data", get_beat(0).data,
            256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
      check("t2_last_data", get_beat(8).data, 256'h00020013_00020012_00020011_00020010);
      check("t2_back_to_back", get_beat(1).cyc - get_beat(0).cyc, 1);
      check("t2_gap_a", get_beat(3).cyc - get_beat(2).cyc, 3);
      check("t2_gap_b", get_beat(6).cyc - get_beat(5).cyc, 3);
      check("t2_done_time", done_cycs.size() > 0 ? done_cycs[0] - get_beat(8).cyc : -1, 1);
      check("t2_pkt_cnt", pkt_cnt, 3);
      ref_beats = beats;

      // same burst with random backpressure
      run_burst("t3", 3, 20, 64'h1000, 2, 1, -1, t0);
      check("t3_nbeats", beats.size(), ref_beats.size());
      for (int i = 0; i < ref_beats.size(); i++)
         check($sformatf("t3_beat%0d", i), beat_vec(get_beat(i)), beat_vec(ref_beats[i]));
      check("t3_pkt_cnt", pkt_cnt, 3);

      // abort during packet 4 of 10
      run_burst("t4", 10, 20, 64'h0, 0, 0, 13, t0);
      check("t4_nbeats", beats.size(), 15);
      check("t4_last_eop", get_beat(14).eop, 1);
      check("t4_last_tag", get_beat(12).hdr[79:72], 8'd4);
      check("t4_done_time", done_cycs.size() > 0 ? done_cycs[0] - get_beat(14).cyc : -1, 1);
      check("t4_pkt_cnt", pkt_cnt, 5);
      run_burst("t4b", 1, 8, 64'h4000, 0, 0, -1, t0);
      check("t4b_nbeats", beats.size(), 1);
      check("t4b_hdr", get_beat(0).hdr, 128'h60000008_000000FF_00000000_00004000);
      check("t4b_pkt_cnt", pkt_cnt, 1);

      // len=0 treated as 1, misaligned address
      run_burst("t5a", 2, 0, 64'h2003, 0, 0, -1, t0);
      check("t5a_nbeats", beats.size(), 2);
      check("t5a_flags", {get_beat(0).sop, get_beat(0).eop, get_beat(0).empty}, {1'b1, 1'b1, 3'd7});
      check("t5a_hdr0", get_beat(0).hdr, 128'h60000001_0000000F_00000000_00002000);
      check("t5a_hdr1", get_beat(1).hdr, 128'h60000001_0000010F_00000000_00002004);
      check("t5a_data1", get_beat(1).data, 256'h0001_0000);

      // len above maximum clamps to 64
      run_burst("t5b", 1, 100, 64'h3000, 0, 0, -1, t0);
      check("t5b_nbeats", beats.size(), 8);
      check("t5b_hdr", get_beat(0).hdr, 128'h60000040_000000FF_00000000_00003000);
      check("t5b_eop", {get_beat(7).eop, get_beat(7).empty, get_beat(6).eop}, {1'b1, 3'd0, 1'b0});
      check("t5b_last_dw", get_beat(7).data[255:224], 32'h0000_003F);

      // address wrap at 2^64
      run_burst("t5c", 2, 8, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, -1, t0);
      check("t5c_hdr0", get_beat(0).hdr, 128'h60000008_000000FF_FFFFFFFF_FFFFFFF0);
      check("t5c_hdr1", get_beat(1).hdr, 128'h60000008_000001FF_00000000_00000010);
      check("t5c_data1", get_beat(1).data[31:0], 32'h0001_0000);

      // reset during the second beat of a 3-beat packet
      beats.delete();
      @(posedge clk); #1;
      cfg_num_pkts = 16'd3;
      cfg_len_dw   = 7'd20;
      cfg_addr     = 64'h5000;
      cfg_gap      = 8'd0;
      start        = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      fin = 0;
      for (int i = 0; i < 50 && !fin; i++) begin
         @(negedge clk); #1;
         if (beats.size() == 2) fin = 1;
      end
      check("t6_reach_beat", fin, 1);
      check("t6_busy_before", busy, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_reset_outs", {out_valid, out_sop, out_eop, busy, done, pkt_cnt, out_hdr, out_data, out_empty}, '0);

      run_burst("t6b", 0, 8, 64'h0, 0, 0, -1, t0);
      check("t6b_done_time", done_cycs.size() > 0 ? done_cycs[0] - t0 : -1, 1);
      check("t6b_no_beats", beats.size(), 0);
      check("t6b_idle", {out_valid, busy, pkt_cnt}, '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/tlp_gen.md
Name: tlp_gen

Overview:
- Synthesizable, parametrised TLP stimulus source for the PCIe-to-AXI TX path.
- Emits a programmed burst of memory-write TLPs over a valid/ready streaming interface, one header per packet on the SOP beat.
- Payloads are multi-beat, with programmable length, inter-packet gap and incrementing address.
- Drives the bridge TX input in simulation and in on-board loopback/self-test.

Parameters:
- DW, 32, double-word width in bits.
- HEADER_SIZE, 4*DW, header width (4DW header, 64-bit addressing).
- TLP_DATA_WIDTH, 8*DW, data beat width.
- MAX_LEN_DW, 64, maximum payload length in DW; must be ≤1023.
- LEN_W, $clog2(MAX_LEN_DW+1), width of the length config field.
- BEAT_DW, TLP_DATA_WIDTH/DW, DWs per beat (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; begin burst; ignored unless idle.
- abort  in  1  stop burst at next packet boundary.
- cfg_num_pkts  in  16  packets per burst; 0 means done with no traffic.
- cfg_len_dw  in  LEN_W  payload DW per packet; 0 treated as 1; >MAX_LEN_DW clamped to MAX_LEN_DW.
- cfg_addr  in  64  first packet address; bits [1:0] are forced to 0.
- cfg_gap  in  8  idle cycles inserted between packets.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- pkt_cnt  out  16  packets fully accepted in the current or last burst.
- out_ready  in  1  sink ready.
- out_valid  out  1  beat valid.
- out_sop  out  1  first beat of packet.
- out_eop  out  1  last beat of packet.
- out_hdr  out  HEADER_SIZE  TLP header; meaningful only when out_sop=1, otherwise 0.
- out_data  out  TLP_DATA_WIDTH  payload beat; DW k occupies bits [DW*k +: DW].
- out_empty  out  $clog2(BEAT_DW)  unused DWs in the EOP beat; 0 on other beats.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
  - Reset mid-packet abandons the packet immediately (valid drops at the reset edge).
- Configuration: all cfg_* sampled on the cycle start is accepted in IDLE. Changing cfg_* during a burst has no effect.
- FSM:
  - IDLE: on start, go to SEND if cfg_num_pkts≠0; otherwise pulse done next cycle and stay IDLE.
  - SEND: present beats. On an EOP handshake:
    - if this was the last packet, or abort is latched: go to DONE;
    - else if gap≠0: go to GAP;
    - else: next packet's SOP beat is presented the following cycle.
  - GAP: out_valid=0 for exactly cfg_gap cycles, then SEND.
  - DONE: one cycle; done=1, busy=0 afterwards; return to IDLE.
- Latency: start accepted at edge T → out_valid=1 (SOP) after edge T+1. done is high the cycle after the final EOP handshake.
- Handshake:
  - Beat transfers when out_valid&&out_ready.
  - While out_valid&&!out_ready, all out_* stay stable.
  - out_valid never drops without a handshake, except on reset.
- Beats per packet: ceil(len/BEAT_DW). A 1-beat packet has out_sop=out_eop=1.
- out_empty on EOP beat = (BEAT_DW − len mod BEAT_DW) mod BEAT_DW. Unused DWs are driven 0.
- Header layout (all other header bits 0):
  - DW0 (hdr[127:96]): fmt=3'b011 at [127:125], type=5'b00000 at [124:120], length at [105:96] = effective len.
  - DW1 (hdr[95:64]): tag=packet index[7:0] at [79:72], first BE=4'hF at [67:64], last BE=4'hF at [71:68] if len>1 else 4'h0.
  - hdr[63:0]: address.
- Address: packet p address = cfg_addr + p*len*4, mod 2^64 (wrap-around allowed).
- Payload pattern: global DW index k within packet p carries {p[15:0], k[15:0]}.
- pkt_cnt:
  - increments on each EOP handshake;
  - cleared when start is accepted;
  - held after done.
- busy: 1 from the cycle after start is accepted until DONE.
- abort:
  - latched when asserted while busy;
  - takes effect at the next EOP handshake (the packet in flight completes);
  - in GAP, takes effect immediately → DONE;
  - cleared on exit to IDLE;
  - ignored in IDLE.
- start while busy is ignored.

Decomposition:
- Shared package tlp_pkg holds:
  - localparams FMT_MWR64=3'b011, TYPE_MEM=5'b00000;
  - header field bit offsets;
  - function build_hdr(len, tag, addr).
- One sub-module tlp_beat_fmt: combinational payload/empty generator from (pkt index, beat index, len).
- The FSM, counters and output register stage live in tlp_gen.

Test Plan:
- len=8, num_pkts=1, gap=0, ready=1, addr=0x1000 → one beat, sop=eop=1, empty=0, hdr[105:96]=8, hdr[63:0]=0x1000, DW3 of data=0x0000_0003, done 1 cycle after the handshake.
- len=20, num_pkts=3, gap=2 → 3 beats per packet, EOP empty=4, valid low exactly 2 cycles between packets, addresses 0x1000/0x1050/0x10A0, tags 0/1/2, pkt_cnt=3.
- Same as above with ready toggled pseudo-randomly at 50% → all out_* stable across stall cycles; identical beat sequence to the ready=1 run.
- num_pkts=10, abort pulsed mid-packet 4 → packet 4 completes, done follows, pkt_cnt=5; a new start is accepted afterwards.
- len=0 → treated as 1: empty=7, last BE=0. len=100 with MAX_LEN_DW=64 → length field=64. addr=0xFFFF_FFFF_FFFF_FFF0, len=8 → second packet address wraps to 0x10.
- rst_n low for 1 cycle during beat 2 of a 3-beat packet → all outputs 0 next cycle, FSM IDLE; start with num_pkts=0 → done pulse, no valid.
